psram_access_arbiter: RTL and testbench

Schedules the single QPI PSRAM command engine between three requesters: display read-FIFO refill, burst write-back, and the MCU pass-through window.
Sits between the requesters and the PSRAM engine. The engine owns CS/CLK/SIO timing; this block owns who goes next, and when.
Display refill gets urgent priority when its FIFO runs low. Otherwise non-urgent work is served round-robin. An MCU window can be asked to yield.

---
 rtl/psram_access_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_psram_access_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_access_arbiter.sv
// psram_access_arbiter
// Decides which requester (display refill, write-back burst or MCU window)
// drives the shared QPI PSRAM command engine next, and enforces the CS-high
// gap between engine transactions.
// Optional build macro: ARB_WATCHDOG_EN adds an engine-completion watchdog
// and the sticky arb_err output.
module psram_access_arbiter #(
  parameter int FIFO_DEPTH  = 512,
  parameter int LOW_WM      = 64,
  parameter int REFILL_LEN  = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_done,
  input  logic        disp_req,
  input  logic [23:0] disp_addr,
  input  logic [9:0]  disp_wrusedw,
  output logic        disp_ack,
  input  logic        wr_req,
  input  logic [23:0] wr_addr,
  input  logic [6:0]  wr_len,
  output logic        wr_ack,
  input  logic        mcu_req,
  output logic        mcu_ack,
  output logic        mcu_yield,
  output logic        eng_start,
  output logic [1:0]  eng_cmd,
  output logic [23:0] eng_addr,
  output logic [6:0]  eng_len,
  input  logic        eng_done,
  output logic [1:0]  grant_id
`ifdef ARB_WATCHDOG_EN
  ,
  output logic        arb_err
`endif
);

  // Requester indices used by the round-robin pointer
  localparam logic [1:0] REQ_DISP = 2'd0;
  localparam logic [1:0] REQ_WR   = 2'd1;
  localparam logic [1:0] REQ_MCU  = 2'd2;

  // Values presented on grant_id
  localparam logic [1:0] GID_NONE = 2'd0;
  localparam logic [1:0] GID_DISP = 2'd1;
  localparam logic [1:0] GID_WR   = 2'd2;
  localparam logic [1:0] GID_MCU  = 2'd3;

  // Engine command encodings
  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_OPEN  = 2'd2;
  localparam logic [1:0] CMD_CLOSE = 2'd3;

  // A display refill moves REFILL_LEN 16-bit entries, i.e. twice as many bytes
  localparam logic [6:0]  DISP_LEN = 7'(2 * REFILL_LEN);
  localparam logic [10:0] DEPTH_11 = 11'(FIFO_DEPTH);
  localparam logic [10:0] LOW_WM_11 = 11'(LOW_WM);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    BUSY,
    OPENING,
    MCU_HOLD,
    CLOSING,
    GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        rr_ptr_reg, rr_ptr_next;
  logic              eng_start_reg, eng_start_next;
  logic [1:0]        eng_cmd_reg, eng_cmd_next;
  logic [23:0]       eng_addr_reg, eng_addr_next;
  logic [6:0]        eng_len_reg, eng_len_next;
  logic [1:0]        grant_reg, grant_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;

  logic [10:0]       disp_free;
  logic              urgent;
  logic [2:0]        req_vec;
  logic [1:0]        rr_cand [3];
  logic              rr_found;
  logic [1:0]        rr_sel;
  logic              grant_take;
  logic [1:0]        grant_sel;

  // Free space in the display FIFO; 11-bit unsigned so FIFO_DEPTH itself fits
  assign disp_free = DEPTH_11 - {1'b0, disp_wrusedw};
  assign urgent    = disp_req && (disp_free >= LOW_WM_11);
  assign req_vec   = {mcu_req, wr_req, disp_req};

  // Candidate order for round-robin: rr_ptr first, then the two after it
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_rr_cand
    logic [2:0] rot_sum;
    assign rot_sum     = {1'b0, rr_ptr_reg} + 3'(gi);
    assign rr_cand[gi] = (rot_sum >= 3'd3) ? 2'(rot_sum - 3'd3) : rot_sum[1:0];
  end

  // Round-robin winner among the pending requesters, first hit in rotated order
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = REQ_DISP;
    for (int k = 0; k < 3; k++) begin
      if (!rr_found && req_vec[rr_cand[k]]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand[k];
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt_reg;
  logic              wdog_active;
  logic              wdog_expired;
  logic              arb_err_reg, arb_err_next;

  assign wdog_active  = (state_reg == BUSY) || (state_reg == OPENING) ||
                        (state_reg == CLOSING);
  assign wdog_expired = wdog_active && !eng_done &&
                        (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES));

  // Cycles spent waiting on the engine; held at zero outside the wait states
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog_cnt_reg <= '0;
    end else if (!wdog_active) begin
      wdog_cnt_reg <= '0;
    end else if (wdog_cnt_reg != WDOG_W'(WDOG_CYCLES)) begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end
  end

  assign arb_err = arb_err_reg;
`endif

  // Next-state and registered-output logic of the scheduling FSM
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    eng_start_next = 1'b0;
    eng_cmd_next   = eng_cmd_reg;
    eng_addr_next  = eng_addr_reg;
    eng_len_next   = eng_len_reg;
    grant_next     = grant_reg;
    gap_cnt_next   = gap_cnt_reg;
    grant_take     = 1'b0;
    grant_sel      = REQ_DISP;
`ifdef ARB_WATCHDOG_EN
    arb_err_next   = arb_err_reg;
`endif

    case (state_reg)
      WAIT_INIT: begin
        if (init_done) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        // An urgent display jumps the queue without consuming a round-robin
        // turn, so whoever was next keeps that slot.
        if (urgent) begin
          grant_take = 1'b1;
          grant_sel  = REQ_DISP;
        end else if (rr_found) begin
          grant_take  = 1'b1;
          grant_sel   = rr_sel;
          rr_ptr_next = (rr_sel == REQ_MCU) ? REQ_DISP : rr_sel + 2'd1;
        end

        if (grant_take) begin
          eng_start_next = 1'b1;
          case (grant_sel)
            REQ_DISP: begin
              eng_cmd_next  = CMD_READ;
              eng_addr_next = disp_addr;
              eng_len_next  = DISP_LEN;
              grant_next    = GID_DISP;
              state_next    = BUSY;
            end
            REQ_WR: begin
              // A length of 0 already encodes 64 bytes for the engine
              eng_cmd_next  = CMD_WRITE;
              eng_addr_next = wr_addr;
              eng_len_next  = wr_len;
              grant_next    = GID_WR;
              state_next    = BUSY;
            end
            default: begin
              eng_cmd_next  = CMD_OPEN;
              eng_addr_next = '0;
              eng_len_next  = '0;
              grant_next    = GID_MCU;
              state_next    = OPENING;
            end
          endcase
        end
      end

      BUSY: begin
        if (eng_done) begin
          grant_next   = GID_NONE;
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end

      OPENING: begin
        if (eng_done) begin
          state_next = MCU_HOLD;
        end
      end

      MCU_HOLD: begin
        // The window stays open until the MCU lets go; yield is only a hint
        if (!mcu_req) begin
          eng_start_next = 1'b1;
          eng_cmd_next   = CMD_CLOSE;
          state_next     = CLOSING;
        end
      end

      CLOSING: begin
        if (eng_done) begin
          grant_next   = GID_NONE;
          gap_cnt_next = '0;
          state_next   = GAP;
        end
      end

      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = WAIT_INIT;
      end
    endcase

`ifdef ARB_WATCHDOG_EN
    // Engine never answered: abort the command and drop the requester
    if (wdog_expired) begin
      eng_start_next = 1'b1;
      eng_cmd_next   = CMD_CLOSE;
      grant_next     = GID_NONE;
      gap_cnt_next   = '0;
      arb_err_next   = 1'b1;
      state_next     = GAP;
    end
`endif
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= WAIT_INIT;
      rr_ptr_reg    <= REQ_DISP;
      eng_start_reg <= 1'b0;
      eng_cmd_reg   <= CMD_READ;
      eng_addr_reg  <= '0;
      eng_len_reg   <= '0;
      grant_reg     <= GID_NONE;
      gap_cnt_reg   <= '0;
`ifdef ARB_WATCHDOG_EN
      arb_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      eng_start_reg <= eng_start_next;
      eng_cmd_reg   <= eng_cmd_next;
      eng_addr_reg  <= eng_addr_next;
      eng_len_reg   <= eng_len_next;
      grant_reg     <= grant_next;
      gap_cnt_reg   <= gap_cnt_next;
`ifdef ARB_WATCHDOG_EN
      arb_err_reg   <= arb_err_next;
`endif
    end
  end

  assign eng_start = eng_start_reg;
  assign eng_cmd   = eng_cmd_reg;
  assign eng_addr  = eng_addr_reg;
  assign eng_len   = eng_len_reg;
  assign grant_id  = grant_reg;

  // Acks fire in the eng_done cycle; a reset in that cycle suppresses them
  assign disp_ack  = reset_n && eng_done && (state_reg == BUSY) && (grant_reg == GID_DISP);
  assign wr_ack    = reset_n && eng_done && (state_reg == BUSY) && (grant_reg == GID_WR);
  assign mcu_ack   = reset_n && (state_reg == MCU_HOLD);
  assign mcu_yield = reset_n && (state_reg == MCU_HOLD) && urgent;

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Testbench for psram_access_arbiter: a small engine model answers each
// strobe, expected strobes are queued when requests are driven and popped
// when the arbiter issues them.
module tb_psram_access_arbiter;

  localparam int GAP_CYCLES = 4;
  localparam int ENG_LAT    = 3;

  localparam int W_DACK  = 0;
  localparam int W_WACK  = 1;
  localparam int W_MACK  = 2;
  localparam int W_DRAIN = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_done;
  logic        disp_req;
  logic [23:0] disp_addr;
  logic [9:0]  disp_wrusedw;
  logic        disp_ack;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [6:0]  wr_len;
  logic        wr_ack;
  logic        mcu_req;
  logic        mcu_ack;
  logic        mcu_yield;
  logic        eng_start;
  logic [1:0]  eng_cmd;
  logic [23:0] eng_addr;
  logic [6:0]  eng_len;
  logic        eng_done;
  logic [1:0]  grant_id;
`ifdef ARB_WATCHDOG_EN
  logic        arb_err;
`endif

  typedef struct {
    logic [1:0]  cmd;
    logic [23:0] addr;
    logic [6:0]  len;
    logic [1:0]  gid;
    bit          chk_al;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int n_disp_ack = 0;
  int n_wr_ack = 0;
  int cyc = 0;
  int last_done_cyc = -1000;
  logic [1:0] cur_gid = 2'd0;
  bit  eng_hold = 1'b0;
  int  kick_req = 0;
  int  kick_ack = 0;
  int  eng_cnt = 0;

  psram_access_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_done    (init_done),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_wrusedw (disp_wrusedw),
    .disp_ack     (disp_ack),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_len       (wr_len),
    .wr_ack       (wr_ack),
    .mcu_req      (mcu_req),
    .mcu_ack      (mcu_ack),
    .mcu_yield    (mcu_yield),
    .eng_start    (eng_start),
    .eng_cmd      (eng_cmd),
    .eng_addr     (eng_addr),
    .eng_len      (eng_len),
    .eng_done     (eng_done),
    .grant_id     (grant_id)
`ifdef ARB_WATCHDOG_EN
    ,
    .arb_err      (arb_err)
`endif
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] cmd, input logic [23:0] addr,
                          input logic [6:0] len, input logic [1:0] gid, input bit chk);
    exp_t e;
    e.cmd = cmd; e.addr = addr; e.len = len; e.gid = gid; e.chk_al = chk;
    exp_q.push_back(e);
  endtask

  task automatic wait_for(input string tag, input int which, input int target, input int budget);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (which)
        W_DACK:  hit = (n_disp_ack >= target);
        W_WACK:  hit = (n_wr_ack >= target);
        W_MACK:  hit = (mcu_ack == target[0]);
        default: hit = (exp_q.size() == 0);
      endcase
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  task automatic check_quiet(input string pfx);
    check_val({pfx, "_eng_start"}, 32'(eng_start), 32'd0);
    check_val({pfx, "_eng_cmd"},   32'(eng_cmd),   32'd0);
    check_val({pfx, "_eng_addr"},  32'(eng_addr),  32'd0);
    check_val({pfx, "_eng_len"},   32'(eng_len),   32'd0);
    check_val({pfx, "_grant_id"},  32'(grant_id),  32'd0);
    check_val({pfx, "_disp_ack"},  32'(disp_ack),  32'd0);
    check_val({pfx, "_wr_ack"},    32'(wr_ack),    32'd0);
    check_val({pfx, "_mcu_ack"},   32'(mcu_ack),   32'd0);
    check_val({pfx, "_mcu_yield"}, 32'(mcu_yield), 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    init_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    reset_n = 1'b1;
  endtask

  // Engine model: answers each accepted strobe ENG_LAT cycles later,
  // or emits a lone eng_done when the main sequence asks for one
  initial begin : engine_model
    eng_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (kick_req != kick_ack) begin
        eng_done = 1'b1;
        kick_ack++;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1'b1;
      end
      if (eng_start && !eng_hold) eng_cnt = ENG_LAT;
    end
  end

  // Monitor: pops the expected strobe, checks acks against the owner
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (disp_ack) n_disp_ack++;
      if (wr_ack) n_wr_ack++;
      if (eng_start) begin
        $display("%0t strobe cmd=%0d addr=%06h len=%0d gid=%0d", $time, eng_cmd, eng_addr, eng_len, grant_id);
        if (exp_q.size() == 0) begin
          check_val("unexpected_strobe", 32'(eng_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("strobe_cmd", 32'(eng_cmd), 32'(e.cmd));
          check_val("strobe_gid", 32'(grant_id), 32'(e.gid));
          if (e.chk_al) begin
            check_val("strobe_addr", 32'(eng_addr), 32'(e.addr));
            check_val("strobe_len", 32'(eng_len), 32'(e.len));
          end
          if (e.cmd != 2'd3) begin
            check_val("cs_gap", 32'(((cyc - last_done_cyc) >= GAP_CYCLES + 1) ? 1 : 0), 32'd1);
          end
          cur_gid = e.gid;
        end
      end
      if (eng_done) begin
        check_val("disp_ack_at_done", 32'(disp_ack), 32'((reset_n && cur_gid == 2'd1) ? 1 : 0));
        check_val("wr_ack_at_done", 32'(wr_ack), 32'((reset_n && cur_gid == 2'd2) ? 1 : 0));
        last_done_cyc = cyc;
      end else if (disp_ack || wr_ack) begin
        check_val("ack_without_done", 32'(disp_ack | wr_ack), 32'd0);
      end
    end
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main_seq
    int base_d;
    int base_w;
    reset_n = 1'b0; init_done = 1'b0;
    disp_req = 1'b0; disp_addr = '0; disp_wrusedw = '0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; mcu_req = 1'b0;

    // Single non-urgent refill after init
    apply_reset();
    base_d = n_disp_ack;
    disp_addr = 24'h000640; disp_wrusedw = 10'd500; disp_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_val("wait_init_gid", 32'(grant_id), 32'd0);
    push_exp(2'd0, 24'h000640, 7'd32, 2'd1, 1'b1);
    init_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("idle_no_strobe", 32'(eng_start), 32'd0);
    @(negedge clk);
    check_val("strobe_latency", 32'(eng_start), 32'd1);
    wait_for("t1_disp_ack", W_DACK, base_d + 1, 50);
    @(posedge clk); #1 disp_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("t1_one_ack", 32'(n_disp_ack - base_d), 32'd1);

    // All three held: display, write, MCU, display
    apply_reset();
    init_done = 1'b1;
    base_d = n_disp_ack; base_w = n_wr_ack;
    disp_addr = 24'h001000; wr_addr = 24'h002000; wr_len = 7'd5; disp_wrusedw = 10'd500;
    push_exp(2'd0, 24'h001000, 7'd32, 2'd1, 1'b1);
    push_exp(2'd1, 24'h002000, 7'd5, 2'd2, 1'b1);
    push_exp(2'd2, 24'h0, 7'd0, 2'd3, 1'b0);
    disp_req = 1'b1; wr_req = 1'b1; mcu_req = 1'b1;
    wait_for("t2_mcu_open", W_MACK, 1, 150);
    check_val("t2_gid_mcu", 32'(grant_id), 32'd3);
    check_val("t2_no_yield", 32'(mcu_yield), 32'd0);
    push_exp(2'd3, 24'h0, 7'd0, 2'd3, 1'b0);
    push_exp(2'd0, 24'h001000, 7'd32, 2'd1, 1'b1);
    repeat (3) @(posedge clk);
    #1 mcu_req = 1'b0;
    wait_for("t2_disp_again", W_DACK, base_d + 2, 100);
    @(posedge clk); #1 disp_req = 1'b0; wr_req = 1'b0;
    wait_for("t2_drain", W_DRAIN, 0, 50);
    repeat (10) @(posedge clk);
    #1;
    check_val("t2_wr_acks", 32'(n_wr_ack - base_w), 32'd1);
    check_val("t2_mcu_closed", 32'(mcu_ack), 32'd0);

    // MCU window, display turns urgent, yield, then display before write
    base_d = n_disp_ack; base_w = n_wr_ack;
    push_exp(2'd2, 24'h0, 7'd0, 2'd3, 1'b0);
    mcu_req = 1'b1;
    wait_for("t3_mcu_open", W_MACK, 1, 50);
    check_val("t3_no_yield_yet", 32'(mcu_yield), 32'd0);
    @(posedge clk);
    #1;
    disp_addr = 24'h003000; disp_wrusedw = 10'd400; disp_req = 1'b1;
    wr_addr = 24'hFFFFC0; wr_len = 7'd0; wr_req = 1'b1;
    push_exp(2'd3, 24'h0, 7'd0, 2'd3, 1'b0);
    push_exp(2'd0, 24'h003000, 7'd32, 2'd1, 1'b1);
    push_exp(2'd1, 24'hFFFFC0, 7'd0, 2'd2, 1'b1);
    @(negedge clk);
    check_val("t3_yield", 32'(mcu_yield), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check_val("t3_no_self_close", 32'(mcu_ack), 32'd1);
    mcu_req = 1'b0;
    wait_for("t3_disp_ack", W_DACK, base_d + 1, 100);
    @(posedge clk); #1 disp_req = 1'b0; disp_wrusedw = 10'd500;
    wait_for("t3_wr_ack", W_WACK, base_w + 1, 100);
    @(posedge clk); #1 wr_req = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check_val("t3_one_wr_ack", 32'(n_wr_ack - base_w), 32'd1);
    check_val("t3_drained", 32'(exp_q.size()), 32'd0);

    // Urgent display beats the MCU even though the MCU is next in turn
    base_d = n_disp_ack;
    push_exp(2'd0, 24'h004000, 7'd32, 2'd1, 1'b1);
    push_exp(2'd2, 24'h0, 7'd0, 2'd3, 1'b0);
    disp_addr = 24'h004000; disp_wrusedw = 10'd400; disp_req = 1'b1; mcu_req = 1'b1;
    wait_for("t5_disp_ack", W_DACK, base_d + 1, 100);
    @(posedge clk); #1 disp_req = 1'b0; disp_wrusedw = 10'd500;
    wait_for("t5_mcu_open", W_MACK, 1, 100);
    push_exp(2'd3, 24'h0, 7'd0, 2'd3, 1'b0);
    @(posedge clk); #1 mcu_req = 1'b0;
    wait_for("t5_drain", W_DRAIN, 0, 50);
    repeat (10) @(posedge clk);
    #1;
    // Stray eng_done while idle must do nothing
    base_d = n_disp_ack; base_w = n_wr_ack;
    kick_req++;
    repeat (6) @(posedge clk);
    #1;
    check_val("stray_done_dack", 32'(n_disp_ack - base_d), 32'd0);
    check_val("stray_done_wack", 32'(n_wr_ack - base_w), 32'd0);
    check_val("stray_done_gid", 32'(grant_id), 32'd0);

    // Reset while a write is in flight
    eng_hold = 1'b1;
    base_w = n_wr_ack;
    push_exp(2'd1, 24'h005000, 7'd9, 2'd2, 1'b1);
    wr_addr = 24'h005000; wr_len = 7'd9; wr_req = 1'b1;
    wait_for("t6_strobe", W_DRAIN, 0, 50);
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_busy_gid", 32'(grant_id), 32'd2);
    reset_n = 1'b0; init_done = 1'b0; wr_req = 1'b0;
    kick_req++;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("t6_rst");
    reset_n = 1'b1; wr_req = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_val("t6_wait_init_gid", 32'(grant_id), 32'd0);
    check_val("t6_no_wr_ack", 32'(n_wr_ack - base_w), 32'd0);
    wr_req = 1'b0; eng_hold = 1'b0;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
